// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB UART register block.
package apb_uart_pkg;

    // Register byte offsets (only paddr[4:2] is decoded)
    localparam logic [4:0] OFF_TX_DATA = 5'h00;
    localparam logic [4:0] OFF_RX_DATA = 5'h04;
    localparam logic [4:0] OFF_CFG     = 5'h08;
    localparam logic [4:0] OFF_CTRL    = 5'h0C;
    localparam logic [4:0] OFF_STATUS  = 5'h10;
    localparam logic [4:0] OFF_IER     = 5'h14;

    // STATUS bit positions
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_TX_DONE    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_RX_OVERRUN = 4;

    // Frame configuration as seen by the UART core
    typedef struct packed {
        logic       odd_parity;  // [4]
        logic       parity_en;   // [3]
        logic       two_stop;    // [2]
        logic [1:0] data_bits;   // [1:0] 0..3 -> 5..8 bits
    } uart_cfg_t;

    // Byte offset of a decoded APB address
    function automatic logic [4:0] reg_off(input logic [2:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/apb_uart_status.sv
// Sticky status flags, RX data capture and the registered interrupt.
module apb_uart_status
    import apb_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_done_in,
    input  logic       rx_done_in,
    input  logic       parity_error_in,
    input  logic [7:0] rx_data_in,
    input  logic       rx_rd_i,        // completed APB read of RX_DATA
    input  logic       w1c_i,          // completed APB write of STATUS
    input  logic [3:0] w1c_mask_i,     // write data bits [4:1]
    input  logic [3:0] ier_i,          // enables for STATUS[4:1]
    output logic [3:0] flags_o,        // STATUS[4:1]
    output logic [7:0] rx_data_o,
    output logic       irq_o
);

    logic       tx_done_q, tx_done_d;
    logic       rx_valid_q, rx_valid_d;
    logic       par_err_q, par_err_d;
    logic       overrun_q, overrun_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       irq_q, irq_d;

    logic clr_tx_done, clr_par_err, clr_overrun;

    assign clr_tx_done = w1c_i & w1c_mask_i[ST_TX_DONE-1];
    assign clr_par_err = w1c_i & w1c_mask_i[ST_PARITY_ERR-1];
    assign clr_overrun = w1c_i & w1c_mask_i[ST_RX_OVERRUN-1];

    // Next-state for flags: hardware set always beats a software clear
    always_comb begin
        tx_done_d  = tx_done_in | (tx_done_q & ~clr_tx_done);
        par_err_d  = (rx_done_in & parity_error_in) | (par_err_q & ~clr_par_err);
        // A read racing a new byte consumes the old byte, so no overrun
        overrun_d  = (rx_done_in & rx_valid_q & ~rx_rd_i) | (overrun_q & ~clr_overrun);
        rx_valid_d = rx_valid_q;
        if (rx_done_in)   rx_valid_d = 1'b1;
        else if (rx_rd_i) rx_valid_d = 1'b0;
        rx_data_d  = rx_done_in ? rx_data_in : rx_data_q;
        irq_d      = |(flags_o & ier_i);
    end

    // Flag, data and interrupt registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            tx_done_q  <= tx_done_d;
            rx_valid_q <= rx_valid_d;
            par_err_q  <= par_err_d;
            overrun_q  <= overrun_d;
            rx_data_q  <= rx_data_d;
            irq_q      <= irq_d;
        end
    end

    assign flags_o   = {overrun_q, par_err_q, rx_valid_q, tx_done_q};
    assign rx_data_o = rx_data_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/apb_uart_regs.sv
// APB3 register front-end for the UART core: decode, TX/CFG/IER storage, start pulse.
module apb_uart_regs
    import apb_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            tx_data_out,
    output logic [4:0]            cfg_reg_out,
    output logic                  start_tx_out,
    input  logic                  tx_busy_in,
    input  logic                  tx_done_in,
    input  logic                  rx_done_in,
    input  logic                  parity_error_in,
    input  logic [7:0]            rx_data_in,
    output logic                  irq_out
);

    logic [7:0] tx_data_q, tx_data_d;
    uart_cfg_t  cfg_q, cfg_d;
    logic [3:0] ier_q, ier_d;
    logic       start_q, start_d;

    logic       access, wr_acc, rd_acc;
    logic [4:0] off;
    logic       unmapped, busy_err;
    logic       start_req;
    logic [3:0] flags;
    logic [7:0] rx_data;

    // Address bits outside [4:2] and upper write data are don't-care
    logic unused_bits;
    assign unused_bits = ^{paddr, pwdata};

    assign access   = psel & penable;
    assign wr_acc   = access & pwrite;
    assign rd_acc   = access & ~pwrite;
    assign off      = reg_off(paddr[4:2]);
    assign pready   = 1'b1;

    // Decode errors: holes in the map, and touching frame state while busy
    always_comb begin
        unmapped  = 1'b0;
        busy_err  = 1'b0;
        start_req = 1'b0;
        case (off)
            OFF_TX_DATA, OFF_RX_DATA, OFF_CFG, OFF_STATUS, OFF_IER: ;
            OFF_CTRL: start_req = pwdata[0];
            default:  unmapped = 1'b1;
        endcase
        if (pwrite && tx_busy_in &&
            (off == OFF_TX_DATA || off == OFF_CFG || (off == OFF_CTRL && pwdata[0])))
            busy_err = 1'b1;
        pslverr = access & (unmapped | busy_err);
    end

    // Writable register next-state; a busy-rejected write leaves them alone
    always_comb begin
        tx_data_d = tx_data_q;
        cfg_d     = cfg_q;
        ier_d     = ier_q;
        start_d   = 1'b0;
        if (wr_acc) begin
            case (off)
                OFF_TX_DATA: if (!tx_busy_in) tx_data_d = pwdata[7:0];
                OFF_CFG:     if (!tx_busy_in) cfg_d = uart_cfg_t'(pwdata[4:0]);
                OFF_IER:     ier_d = pwdata[3:0];
                default: ;
            endcase
        end
        // Guard on start_q keeps the pulse single even if penable is held
        start_d = wr_acc & (off == OFF_CTRL) & start_req & ~tx_busy_in & ~start_q;
    end

    // Register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q <= 8'h00;
            cfg_q     <= '0;
            ier_q     <= 4'h0;
            start_q   <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            cfg_q     <= cfg_d;
            ier_q     <= ier_d;
            start_q   <= start_d;
        end
    end

    // Read mux, combinational during any read-direction select
    always_comb begin
        prdata = 32'h0;
        if (psel && !pwrite) begin
            case (off)
                OFF_TX_DATA: prdata[7:0] = tx_data_q;
                OFF_RX_DATA: prdata[7:0] = rx_data;
                OFF_CFG:     prdata[4:0] = cfg_q;
                OFF_STATUS:  prdata[4:0] = {flags, tx_busy_in};
                OFF_IER:     prdata[3:0] = ier_q;
                default:     prdata = 32'h0;
            endcase
        end
    end

    apb_uart_status u_status (
        .clk             (clk),
        .rst             (rst),
        .tx_done_in      (tx_done_in),
        .rx_done_in      (rx_done_in),
        .parity_error_in (parity_error_in),
        .rx_data_in      (rx_data_in),
        .rx_rd_i         (rd_acc & (off == OFF_RX_DATA)),
        .w1c_i           (wr_acc & (off == OFF_STATUS)),
        .w1c_mask_i      (pwdata[4:1]),
        .ier_i           (ier_q),
        .flags_o         (flags),
        .rx_data_o       (rx_data),
        .irq_o           (irq_out)
    );

    assign tx_data_out  = tx_data_q;
    assign cfg_reg_out  = cfg_q;
    assign start_tx_out = start_q;

endmodule

// File: tb/tb_apb_uart_regs.sv
// Directed bench for apb_uart_regs with a behavioural register model.
module tb_apb_uart_regs;

    logic        clk = 0, rst = 1;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [7:0]  paddr = 0;
    logic [31:0] pwdata = 0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data_out;
    logic [4:0]  cfg_reg_out;
    logic        start_tx_out;
    logic        tx_busy_in = 0, tx_done_in = 0, rx_done_in = 0, parity_error_in = 0;
    logic [7:0]  rx_data_in = 0;
    logic        irq_out;

    int tests = 0, errs = 0;

    apb_uart_regs #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_data_out(tx_data_out), .cfg_reg_out(cfg_reg_out),
        .start_tx_out(start_tx_out), .tx_busy_in(tx_busy_in), .tx_done_in(tx_done_in),
        .rx_done_in(rx_done_in), .parity_error_in(parity_error_in),
        .rx_data_in(rx_data_in), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registers named after the software view; updated from the spec rules.
    logic [7:0] m_tx, m_rxd;
    logic [4:0] m_cfg;
    logic [3:0] m_ier;
    logic       m_txd, m_rxv, m_per, m_ovr, m_start, m_irq;

    always @(posedge clk or posedge rst) begin
        automatic bit   acc = psel && penable;
        automatic int   reg_n = int'(paddr[4:2]);  // word number in the map
        automatic bit   is_wr = acc && pwrite;
        automatic bit   rx_read = acc && !pwrite && reg_n == 1;
        automatic bit   sw_clear_txd = is_wr && reg_n == 4 && pwdata[1];
        automatic bit   sw_clear_per = is_wr && reg_n == 4 && pwdata[3];
        automatic bit   sw_clear_ovr = is_wr && reg_n == 4 && pwdata[4];
        if (rst) begin
            m_tx <= 0; m_rxd <= 0; m_cfg <= 0; m_ier <= 0;
            m_txd <= 0; m_rxv <= 0; m_per <= 0; m_ovr <= 0; m_start <= 0; m_irq <= 0;
        end else begin
            m_start <= is_wr && reg_n == 3 && pwdata[0] && !tx_busy_in;
            if (is_wr && reg_n == 0 && !tx_busy_in) m_tx <= pwdata[7:0];
            if (is_wr && reg_n == 2 && !tx_busy_in) m_cfg <= pwdata[4:0];
            if (is_wr && reg_n == 5) m_ier <= pwdata[3:0];
            m_txd <= tx_done_in ? 1'b1 : (sw_clear_txd ? 1'b0 : m_txd);
            m_per <= (rx_done_in && parity_error_in) ? 1'b1 : (sw_clear_per ? 1'b0 : m_per);
            m_ovr <= (rx_done_in && m_rxv && !rx_read) ? 1'b1 : (sw_clear_ovr ? 1'b0 : m_ovr);
            m_rxv <= rx_done_in ? 1'b1 : (rx_read ? 1'b0 : m_rxv);
            if (rx_done_in) m_rxd <= rx_data_in;
            m_irq <= (m_txd && m_ier[0]) || (m_rxv && m_ier[1]) ||
                     (m_per && m_ier[2]) || (m_ovr && m_ier[3]);
        end
    end

    // Compare every cycle, mid-period
    always @(negedge clk) begin
        automatic int          reg_n = int'(paddr[4:2]);
        automatic logic [31:0] exp_rd = 0;
        automatic bit          exp_err;
        if (psel && !pwrite) begin
            case (reg_n)
                0: exp_rd = {24'h0, m_tx};
                1: exp_rd = {24'h0, m_rxd};
                2: exp_rd = {27'h0, m_cfg};
                4: exp_rd = {27'h0, m_ovr, m_per, m_rxv, m_txd, tx_busy_in};
                5: exp_rd = {28'h0, m_ier};
                default: exp_rd = 0;
            endcase
        end
        exp_err = psel && penable &&
                  (reg_n > 5 || (pwrite && tx_busy_in &&
                   (reg_n == 0 || reg_n == 2 || (reg_n == 3 && pwdata[0]))));
        check("model_prdata", prdata, exp_rd);
        check("model_pslverr", {31'h0, pslverr}, {31'h0, exp_err});
        check("model_pready", {31'h0, pready}, 32'h1);
        check("model_tx_data", {24'h0, tx_data_out}, {24'h0, m_tx});
        check("model_cfg", {27'h0, cfg_reg_out}, {27'h0, m_cfg});
        check("model_start", {31'h0, start_tx_out}, {31'h0, m_start});
        check("model_irq", {31'h0, irq_out}, {31'h0, m_irq});
    end

    // ---------------- stimulus helpers ----------------
    task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input bit with_rx, input logic [7:0] rxd, input bit with_txd,
                       output logic [31:0] rdat, output logic err);
        @(posedge clk); #1;
        psel = 1; pwrite = wr; paddr = a; pwdata = d; penable = 0;
        @(posedge clk); #1;
        penable = 1;
        if (with_rx) begin rx_done_in = 1; rx_data_in = rxd; end
        if (with_txd) tx_done_in = 1;
        @(negedge clk);
        rdat = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0; rx_done_in = 0; tx_done_in = 0;
    endtask

    task automatic wr(input string n, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] r; logic e;
        apb(1, a, d, 0, 0, 0, r, e);
        check({n, "_err"}, {31'h0, e}, {31'h0, exp_err});
    endtask

    task automatic rd(input string n, input logic [7:0] a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] r; logic e;
        apb(0, a, 0, 0, 0, 0, r, e);
        check(n, r, exp);
        check({n, "_err"}, {31'h0, e}, {31'h0, exp_err});
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic perr);
        @(posedge clk); #1;
        rx_done_in = 1; rx_data_in = d; parity_error_in = perr;
        @(posedge clk); #1;
        rx_done_in = 0; parity_error_in = 0;
    endtask

    initial begin
        logic [31:0] r; logic e;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", prdata, 0);
        check("rst_outs", {tx_data_out, cfg_reg_out, start_tx_out, irq_out, pslverr}, 0);
        #2 rst = 0;

        // Write / readback
        wr("wr_cfg", 8'h08, 32'h1B, 0);
        check("cfg_out", {27'h0, cfg_reg_out}, 32'h1B);
        wr("wr_tx", 8'h00, 32'hA5, 0);
        check("tx_out", {24'h0, tx_data_out}, 32'hA5);
        rd("rd_cfg", 8'h08, 32'h1B, 0);
        rd("rd_tx", 8'h00, 32'hA5, 0);
        wr("wr_ier", 8'h15, 32'hFFFF_FFF3, 0);   // low addr bits ignored
        rd("rd_ier", 8'h14, 32'h3, 0);
        wr("wr_ier0", 8'h14, 32'h0, 0);
        rd("rd_ctrl", 8'h0C, 32'h0, 0);

        // Start pulse: exactly one cycle
        wr("ctrl_start", 8'h0C, 32'h1, 0);
        @(negedge clk); check("start_hi", {31'h0, start_tx_out}, 1);
        @(negedge clk); check("start_lo", {31'h0, start_tx_out}, 0);

        // Busy protection
        tx_busy_in = 1;
        wr("busy_tx", 8'h00, 32'h3C, 1);
        check("busy_tx_kept", {24'h0, tx_data_out}, 32'hA5);
        wr("busy_cfg", 8'h08, 32'h00, 1);
        wr("busy_ctrl", 8'h0C, 32'h1, 1);
        @(negedge clk); check("busy_no_start", {31'h0, start_tx_out}, 0);
        wr("busy_ctrl0", 8'h0C, 32'h0, 0);
        rd("st_busy", 8'h10, 32'h01, 0);
        tx_busy_in = 0;

        // RX capture and read-clear
        rx_pulse(8'h5A, 0);
        rd("st_rxv", 8'h10, 32'h04, 0);
        rd("rx_5a", 8'h04, 32'h5A, 0);
        rd("st_clr", 8'h10, 32'h00, 0);
        wr("wr_ro", 8'h04, 32'hFF, 0);

        // Overrun
        rx_pulse(8'h11, 0);
        rx_pulse(8'h22, 0);
        rd("st_ovr", 8'h10, 32'h14, 0);
        rd("rx_22", 8'h04, 32'h22, 0);
        wr("w1c_ovr", 8'h10, 32'h10, 0);
        rd("st_ovr_clr", 8'h10, 32'h00, 0);

        // Read racing a new byte
        rx_pulse(8'h66, 0);
        apb(0, 8'h04, 0, 1, 8'h77, 0, r, e);
        check("race_old", r, 32'h66);
        rd("race_st", 8'h10, 32'h04, 0);
        rd("race_new", 8'h04, 32'h77, 0);

        // W1C racing tx_done: set wins
        @(posedge clk); #1 tx_done_in = 1;
        @(posedge clk); #1 tx_done_in = 0;
        rd("st_txd", 8'h10, 32'h02, 0);
        apb(1, 8'h10, 32'h02, 0, 0, 1, r, e);
        rd("txd_setwins", 8'h10, 32'h02, 0);
        wr("w1c_txd", 8'h10, 32'h1E, 0);        // RX_VALID not touched by W1C
        rd("st_zero", 8'h10, 32'h00, 0);

        // IRQ: byte pending, then parity-errored byte overruns it
        wr("ier8", 8'h14, 32'h8, 0);
        rx_pulse(8'h01, 0);
        rx_pulse(8'h02, 1);
        @(negedge clk); check("irq_lag", {31'h0, irq_out}, 0);
        @(negedge clk); check("irq_set", {31'h0, irq_out}, 1);
        rd("st_irq", 8'h10, 32'h1C, 0);
        rd("unmapped18", 8'h18, 32'h0, 1);
        wr("unmapped1c", 8'h1C, 32'hFF, 1);
        rd("unmapped_rd1c", 8'h1C, 32'h0, 1);

        // Asynchronous reset in the middle of an access
        @(posedge clk); #1 psel = 1; pwrite = 1; paddr = 8'h00; pwdata = 32'h99;
        @(posedge clk); #1 penable = 1;
        #2 rst = 1;
        #1 check("async_rst", {tx_data_out, cfg_reg_out, start_tx_out, irq_out}, 0);
        @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
        @(posedge clk); #1 rst = 0;
        rd("post_rst_st", 8'h10, 32'h00, 0);
        rd("post_rst_ier", 8'h14, 32'h00, 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    // Hard bound so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
